// File: rtl/branch_resolver_if.sv
// Execute-to-resolver bus: the branch being resolved travels in, and the
// redirect/flush request travels back out to fetch.
interface branch_resolver_if;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  modport master (
    output ex_valid, ex_opcode, ex_func3, ex_pc, ex_target, ex_pred_taken,
           br_eq, br_lt, br_ltu,
    input  redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_func3, ex_pc, ex_target, ex_pred_taken,
           br_eq, br_lt, br_ltu,
    output redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/branch_resolver.sv
// Resolves conditional branches in execute, issues a registered redirect on
// mispredict, and trains a bimodal table of 2-bit counters read by fetch.
module branch_resolver #(
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        fetch_pc,
  output logic               pred_taken,
  branch_resolver_if.slave   ex,
  output logic [CNT_W-1:0]   branch_count,
  output logic [CNT_W-1:0]   mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             resolve;
  logic             taken;
  logic             mispredict;
  logic [31:0]      correct_pc;
  logic [1:0]       cur_cnt;
  logic [1:0]       next_cnt;
  logic             unused_pc_bits;

  assign fetch_idx      = fetch_pc[IDX_W+1:2];
  assign ex_idx         = ex.ex_pc[IDX_W+1:2];
  assign pred_taken     = bht[fetch_idx][1];
  assign unused_pc_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

  // funct3 010/011 are not valid branches and must leave all state untouched.
  assign resolve = ex.ex_valid && (ex.ex_opcode == OP_BRANCH) &&
                   (ex.ex_func3[2:1] != 2'b01);

  always_comb begin
    taken = 1'b0;
    case (ex.ex_func3)
      3'b000:  taken = ex.br_eq;
      3'b001:  taken = !ex.br_eq;
      3'b100:  taken = ex.br_lt;
      3'b101:  taken = !ex.br_lt;
      3'b110:  taken = ex.br_ltu;
      3'b111:  taken = !ex.br_ltu;
      default: taken = 1'b0;
    endcase
  end

  assign mispredict = resolve && (taken != ex.ex_pred_taken);
  assign correct_pc = taken ? ex.ex_target : (ex.ex_pc + 32'd4);
  assign cur_cnt    = bht[ex_idx];

  always_comb begin
    next_cnt = cur_cnt;
    if (taken) begin
      if (cur_cnt != 2'b11) next_cnt = cur_cnt + 2'b01;
    end else begin
      if (cur_cnt != 2'b00) next_cnt = cur_cnt - 2'b01;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      ex.redirect_valid <= 1'b0;
      ex.flush          <= 1'b0;
      ex.redirect_pc    <= 32'd0;
      branch_count      <= '0;
      mispredict_count  <= '0;
    end else begin
      ex.redirect_valid <= mispredict;
      ex.flush          <= mispredict;
      if (mispredict) begin
        ex.redirect_pc   <= correct_pc;
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
      if (resolve) begin
        bht[ex_idx]  <= next_cnt;
        branch_count <= branch_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-computed redirects, counter
// training, illegal/invalid suppression and reset collision.
module tb_branch_resolver;

  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        CLK;
  logic        RST;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;
  int          checks;
  int          errors;

  branch_resolver_if bus ();

  branch_resolver #(.BHT_ENTRIES(16), .CNT_W(16)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .fetch_pc         (fetch_pc),
    .pred_taken       (pred_taken),
    .ex               (bus.slave),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic driveEx(input logic valid, input logic [6:0] opcode,
                         input logic [2:0] func3, input logic [31:0] pc,
                         input logic [31:0] target, input logic pred,
                         input logic eq, input logic lt, input logic ltu);
    bus.ex_valid      = valid;
    bus.ex_opcode     = opcode;
    bus.ex_func3      = func3;
    bus.ex_pc         = pc;
    bus.ex_target     = target;
    bus.ex_pred_taken = pred;
    bus.br_eq         = eq;
    bus.br_lt         = lt;
    bus.br_ltu        = ltu;
  endtask

  task automatic applyStimulus(input logic valid, input logic [6:0] opcode,
                               input logic [2:0] func3, input logic [31:0] pc,
                               input logic [31:0] target, input logic pred,
                               input logic eq, input logic lt, input logic ltu);
    driveEx(valid, opcode, func3, pc, target, pred, eq, lt, ltu);
    tick();
  endtask

  task automatic idle();
    bus.ex_valid = 1'b0;
    tick();
  endtask

  task automatic resetDut();
    bus.ex_valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic checkRedirect(input string tag, input logic valid,
                               input logic [31:0] pc);
    checkOutput({tag, "_valid"}, {31'd0, bus.redirect_valid}, {31'd0, valid});
    checkOutput({tag, "_flush"}, {31'd0, bus.flush}, {31'd0, valid});
    checkOutput({tag, "_pc"}, bus.redirect_pc, pc);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    RST      = 1'b1;
    fetch_pc = 32'h0;
    driveEx(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    RST = 1'b0;

    // Reset state
    fetch_pc = 32'h100;
    #1;
    checkOutput("rst_pred", {31'd0, pred_taken}, 32'd0);
    checkRedirect("rst", 1'b0, 32'h0);
    checkOutput("rst_bcnt", {16'd0, branch_count}, 32'd0);
    checkOutput("rst_mcnt", {16'd0, mispredict_count}, 32'd0);

    // BEQ taken, predicted not taken
    driveEx(1'b1, OP_BR, 3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("beq_pre_update_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    checkRedirect("beq", 1'b1, 32'h140);
    checkOutput("beq_pred_after", {31'd0, pred_taken}, 32'd1);
    idle();
    checkRedirect("beq_pulse_end", 1'b0, 32'h140);
    checkOutput("beq_bcnt", {16'd0, branch_count}, 32'd1);
    checkOutput("beq_mcnt", {16'd0, mispredict_count}, 32'd1);

    // BGEU with ltu=1 -> not taken, predicted taken
    resetDut();
    fetch_pc = 32'h200;
    applyStimulus(1'b1, OP_BR, 3'b111, 32'h200, 32'h280, 1'b1, 1'b0, 1'b0, 1'b1);
    checkRedirect("bgeu", 1'b1, 32'h204);
    checkOutput("bgeu_bcnt", {16'd0, branch_count}, 32'd1);
    checkOutput("bgeu_mcnt", {16'd0, mispredict_count}, 32'd1);
    checkOutput("bgeu_pred", {31'd0, pred_taken}, 32'd0);
    idle();

    // BLT training 01 -> 10 -> 11 -> 11 -> 10
    resetDut();
    fetch_pc = 32'h300;
    applyStimulus(1'b1, OP_BR, 3'b100, 32'h300, 32'h380, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("blt1_rv", {31'd0, bus.redirect_valid}, 32'd1);
    checkOutput("blt1_rpc", bus.redirect_pc, 32'h380);
    checkOutput("blt1_pred", {31'd0, pred_taken}, 32'd1);
    applyStimulus(1'b1, OP_BR, 3'b100, 32'h300, 32'h380, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("blt2_rv", {31'd0, bus.redirect_valid}, 32'd0);
    checkOutput("blt2_rpc_hold", bus.redirect_pc, 32'h380);
    checkOutput("blt2_pred", {31'd0, pred_taken}, 32'd1);
    applyStimulus(1'b1, OP_BR, 3'b100, 32'h300, 32'h380, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("blt3_rv", {31'd0, bus.redirect_valid}, 32'd0);
    checkOutput("blt3_pred", {31'd0, pred_taken}, 32'd1);
    applyStimulus(1'b1, OP_BR, 3'b100, 32'h300, 32'h380, 1'b1, 1'b0, 1'b0, 1'b0);
    checkRedirect("blt4", 1'b1, 32'h304);
    checkOutput("blt4_pred", {31'd0, pred_taken}, 32'd1);
    checkOutput("blt_bcnt", {16'd0, branch_count}, 32'd4);
    checkOutput("blt_mcnt", {16'd0, mispredict_count}, 32'd2);
    idle();

    // Ignored cycles: illegal funct3, ex_valid low, non-branch opcode
    applyStimulus(1'b1, OP_BR, 3'b010, 32'h300, 32'h500, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("f010_rv", {31'd0, bus.redirect_valid}, 32'd0);
    applyStimulus(1'b1, OP_BR, 3'b011, 32'h300, 32'h500, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("f011_rv", {31'd0, bus.redirect_valid}, 32'd0);
    applyStimulus(1'b0, OP_BR, 3'b000, 32'h300, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("novalid_rv", {31'd0, bus.redirect_valid}, 32'd0);
    applyStimulus(1'b1, OP_ALU, 3'b000, 32'h300, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("alu_rv", {31'd0, bus.redirect_valid}, 32'd0);
    checkOutput("ignored_bcnt", {16'd0, branch_count}, 32'd4);
    checkOutput("ignored_mcnt", {16'd0, mispredict_count}, 32'd2);
    checkOutput("ignored_pred", {31'd0, pred_taken}, 32'd1);
    checkOutput("ignored_rpc", bus.redirect_pc, 32'h304);

    // Back-to-back mispredicts on different entries
    applyStimulus(1'b1, OP_BR, 3'b001, 32'h104, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    checkRedirect("bne1", 1'b1, 32'h200);
    applyStimulus(1'b1, OP_BR, 3'b001, 32'h108, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0);
    checkRedirect("bne2", 1'b1, 32'h10C);
    idle();
    checkOutput("bne_bcnt", {16'd0, branch_count}, 32'd6);
    checkOutput("bne_mcnt", {16'd0, mispredict_count}, 32'd4);
    fetch_pc = 32'h104;
    #1;
    checkOutput("bne_idx1_pred", {31'd0, pred_taken}, 32'd1);
    fetch_pc = 32'h108;
    #1;
    checkOutput("bne_idx2_pred", {31'd0, pred_taken}, 32'd0);

    // Reset collides with a mispredicting resolve
    driveEx(1'b1, OP_BR, 3'b000, 32'h300, 32'h380, 1'b1, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.ex_valid = 1'b0;
    checkRedirect("rstcol", 1'b0, 32'h0);
    checkOutput("rstcol_bcnt", {16'd0, branch_count}, 32'd0);
    checkOutput("rstcol_mcnt", {16'd0, mispredict_count}, 32'd0);
    fetch_pc = 32'h300;
    #1;
    checkOutput("rstcol_pred300", {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'h104;
    #1;
    checkOutput("rstcol_pred104", {31'd0, pred_taken}, 32'd0);

    // Wrap of fall-through PC and saturation at strong-NT
    fetch_pc = 32'hFFFF_FFFC;
    applyStimulus(1'b1, OP_BR, 3'b101, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b0);
    checkRedirect("wrap", 1'b1, 32'h0);
    checkOutput("wrap_pred", {31'd0, pred_taken}, 32'd0);
    applyStimulus(1'b1, OP_BR, 3'b101, 32'hFFFF_FFFC, 32'h1000, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sat_nt_rv", {31'd0, bus.redirect_valid}, 32'd0);
    applyStimulus(1'b1, OP_BR, 3'b101, 32'hFFFF_FFFC, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkRedirect("sat_taken", 1'b1, 32'h1000);
    checkOutput("sat_pred", {31'd0, pred_taken}, 32'd0);
    checkOutput("final_bcnt", {16'd0, branch_count}, 32'd3);
    checkOutput("final_mcnt", {16'd0, mispredict_count}, 32'd2);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Branch resolution and prediction-training stage for the pipelined Otter core. Consumes the execute-stage comparison flags (`br_eq`, `br_lt`, `br_ltu`) together with the decoded branch funct3, decides the actual branch outcome, compares it against the fetch-time prediction, and issues a registered redirect/flush on mispredict. It owns a 16-entry bimodal table of 2-bit saturating counters that it trains on every resolved branch. Fetch reads this table combinationally to produce `pred_taken`.

## Interface
Parameters:
- `BHT_ENTRIES`, 16, number of predictor entries (power of two); index = `pc[$clog2(BHT_ENTRIES)+1:2]`
- `CNT_W`, 16, width of performance counters

Ports:
- `CLK`  in  1  clock, all state on rising edge
- `RST`  in  1  synchronous active-high reset
- `fetch_pc`  in  32  fetch-stage PC for prediction lookup
- `pred_taken`  out  1  combinational: MSB of counter at `fetch_pc` index
- `ex_valid`  in  1  execute stage holds a valid instruction this cycle
- `ex_opcode`  in  7  execute instruction opcode
- `ex_func3`  in  3  execute instruction funct3
- `ex_pc`  in  32  execute instruction PC
- `ex_target`  in  32  computed branch target (PC + B-imm)
- `ex_pred_taken`  in  1  prediction carried down the pipe for this instruction
- `br_eq`, `br_lt`, `br_ltu`  in  1 each  comparison flags from the condition generator
- `redirect_valid`  out  1  registered one-cycle pulse: mispredict, fetch must load `redirect_pc`
- `redirect_pc`  out  32  registered corrected PC
- `flush`  out  1  registered, equals `redirect_valid`; kills IF/ID younger instructions
- `branch_count`  out  CNT_W  resolved conditional branches
- `mispredict_count`  out  CNT_W  mispredicted conditional branches

## Operation
- Resolve event: `ex_valid && ex_opcode == 7'b1100011 && ex_func3 ∉ {010, 011}`. All other cycles cause no update, no redirect.
- Outcome: 000 taken=`br_eq`; 001 `!br_eq`; 100 `br_lt`; 101 `!br_lt`; 110 `br_ltu`; 111 `!br_ltu`.
- funct3 010/011 under branch opcode: illegal; ignored entirely (no count, no training, no redirect).
- Mispredict = resolve event && (taken != `ex_pred_taken`). Correct PC = taken ? `ex_target` : `ex_pc + 4` (32-bit wrap, 0xFFFFFFFC+4 = 0).
- Training on every resolve event, index from `ex_pc`: taken → counter+1 saturating at 11; not taken → counter−1 saturating at 00. Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken when MSB=1.
- `branch_count` increments on each resolve event; `mispredict_count` on each mispredict. Both wrap modulo 2^CNT_W.
- JAL/JALR are not handled here.

## Timing
- Reset (`RST` high at edge): all counters := 01 (weak-NT); `redirect_valid`=0, `flush`=0, `redirect_pc`=0, both perf counters=0. Reset wins over a simultaneous resolve event; that event is lost.
- Latency: resolve in cycle N → `redirect_valid`/`flush`/`redirect_pc` visible in cycle N+1, single-cycle pulse. `redirect_pc` holds its last value when `redirect_valid`=0.
- Back-to-back resolve events each produce an independent pulse; consecutive mispredicts give consecutive-cycle pulses.
- Table update takes effect at edge ending cycle N. A lookup in cycle N of the same index returns the pre-update value; cycle N+1 sees the new value.
- `pred_taken` is purely combinational from `fetch_pc` and table state; no handshake.
- Flags and `ex_*` inputs are sampled only in the cycle `ex_valid`=1; block does not stall.

## Test plan
- Reset then lookup any `fetch_pc` → `pred_taken`=0; all outputs 0; counters read 0.
- BEQ at `ex_pc`=0x100, `br_eq`=1, `ex_pred_taken`=0, target 0x140 → next cycle `redirect_valid`=1, `redirect_pc`=0x140, `flush`=1; following cycle both 0; `pred_taken` for 0x100 now 1.
- BGEU at 0x200, `br_ltu`=1, `ex_pred_taken`=1 → not taken, `redirect_pc`=0x204, `mispredict_count`=1, `branch_count`=1.
- Three taken BLTs at 0x300 then one not-taken → counter 01→10→11→11→10; `pred_taken` stays 1; redirect only on first (pred 0) and last (pred 1).
- funct3=010 with branch opcode, or `ex_valid`=0 with valid branch → no redirect, counters unchanged.
- Resolve with mispredict in same cycle as `RST`=1 → no pulse next cycle, all state at reset values; `ex_pc`=0xFFFFFFFC not-taken mispredict → `redirect_pc`=0x00000000.
